// File: rtl/playfield_writer_pkg.sv
// Shared constants for the playfield display/write path.
//   - display timing constants used by the beam pipeline
//   - CPU / playfield widths, IO register selects, status bit positions
//   - write engine state encoding
package playfield_writer_pkg;

  localparam int unsigned H_ACTIVE  = 256;
  localparam int unsigned V_ACTIVE  = 224;

  localparam int unsigned CPU_W     = 12;
  localparam int unsigned PF_ADDR_W = 10;
  localparam int unsigned PF_DATA_W = 8;

  localparam logic [1:0] REG_ADDR  = 2'd0;
  localparam logic [1:0] REG_DATA  = 2'd1;
  localparam logic [1:0] REG_FILLV = 2'd2;
  localparam logic [1:0] REG_FILLC = 2'd3;

  localparam int unsigned STAT_EMPTY    = 0;
  localparam int unsigned STAT_FULL     = 1;
  localparam int unsigned STAT_BUSY     = 2;
  localparam int unsigned STAT_OVERFLOW = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FILL
  } pw_state_t;

endpackage

// File: rtl/playfield_writer_fifo.sv
// Synchronous single-clock FIFO buffering CPU single writes.
// Ports:
//   clock, reset     clock, synchronous active-low reset
//   push, wr_data    enqueue (ignored while full; full is judged before a same-cycle pop)
//   pop,  rd_data    dequeue; rd_data shows the head entry combinationally
//   count/full/empty occupancy
module pf_write_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/playfield_writer.sv
// CPU-side write engine for the playfield tile RAM.
// Ports:
//   clock, reset                 clock, synchronous active-low reset
//   io_sel/io_write/io_read      IO register access (ADDR, DATA, FILLV, FILLC)
//   io_wr_data / io_rd_data      IO write data / combinational read data
//   vblank                       commit window when VBLANK_ONLY=1
//   pf_write/pf_write_addr/pf_wr_data  registered RAM write port
//   busy                         registered: FIFO non-empty or engine active
module playfield_writer
  import playfield_writer_pkg::*;
#(
  parameter int unsigned CPU_W       = playfield_writer_pkg::CPU_W,
  parameter int unsigned ADDR_W      = PF_ADDR_W,
  parameter int unsigned DATA_W      = PF_DATA_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          VBLANK_ONLY = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        io_sel,
  input  logic              io_write,
  input  logic              io_read,
  input  logic [CPU_W-1:0]  io_wr_data,
  output logic [CPU_W-1:0]  io_rd_data,
  input  logic              vblank,
  output logic              pf_write,
  output logic [ADDR_W-1:0] pf_write_addr,
  output logic [DATA_W-1:0] pf_wr_data,
  output logic              busy
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned REM_W   = ADDR_W + 1;

  logic [ADDR_W-1:0]  pointer;
  logic [DATA_W-1:0]  fill_val;
  logic [REM_W-1:0]   fill_rem;
  logic               overflow;
  pw_state_t          state;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;

  logic               commit_ok;
  logic               engine_busy;
  logic               wr_addr;
  logic               wr_data_reg;
  logic               wr_fillv;
  logic               wr_fillc;
  logic               data_reject;
  logic               fillc_reject;
  logic [3:0]         status;
  logic               unused_wr_bits;

  assign commit_ok   = vblank | ~VBLANK_ONLY;
  // Unregistered busy view so a command arriving right behind a DATA
  // write is still judged against the real engine state.
  assign engine_busy = (state != ST_IDLE) | ~fifo_empty | (fill_rem != '0);

  assign wr_addr     = io_write & (io_sel == REG_ADDR);
  assign wr_data_reg = io_write & (io_sel == REG_DATA);
  assign wr_fillv    = io_write & (io_sel == REG_FILLV);
  assign wr_fillc    = io_write & (io_sel == REG_FILLC);

  // fill_rem != 0 covers both an active fill and one about to start.
  assign data_reject  = wr_data_reg & (fifo_full | (fill_rem != '0));
  assign fillc_reject = wr_fillc & engine_busy;
  assign fifo_push    = wr_data_reg & ~data_reject;
  assign fifo_pop     = (state == ST_DRAIN) & commit_ok & ~fifo_empty;

  assign unused_wr_bits = ^io_wr_data[CPU_W-1:REM_W];

  pf_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data ({pointer, io_wr_data[DATA_W-1:0]}),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      pointer       <= '0;
      fill_val      <= '0;
      fill_rem      <= '0;
      overflow      <= 1'b0;
      state         <= ST_IDLE;
      pf_write      <= 1'b0;
      pf_write_addr <= '0;
      pf_wr_data    <= '0;
      busy          <= 1'b0;
    end else begin
      pf_write <= 1'b0;
      busy     <= engine_busy;

      if (wr_fillv) fill_val <= io_wr_data[DATA_W-1:0];

      if (wr_addr)        pointer <= io_wr_data[ADDR_W-1:0];
      else if (fifo_push) pointer <= pointer + ADDR_W'(1);

      if (wr_fillc && !engine_busy) fill_rem <= io_wr_data[REM_W-1:0];

      if (data_reject || fillc_reject)         overflow <= 1'b1;
      else if (io_read && io_sel == REG_FILLC) overflow <= 1'b0;

      if (commit_ok) begin
        case (state)
          ST_IDLE: begin
            if (!fifo_empty)          state <= ST_DRAIN;
            else if (fill_rem != '0)  state <= ST_FILL;
          end
          ST_DRAIN: begin
            if (fifo_pop) begin
              pf_write      <= 1'b1;
              pf_write_addr <= fifo_head[ENTRY_W-1:DATA_W];
              pf_wr_data    <= fifo_head[DATA_W-1:0];
              if (fifo_count == CNT_W'(1) && !fifo_push) state <= ST_IDLE;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_FILL: begin
            if (fill_rem != '0) begin
              pf_write      <= 1'b1;
              pf_write_addr <= pointer;
              pf_wr_data    <= fill_val;
              // The fill engine owns the pointer while filling; this
              // overrides a concurrent ADDR write.
              pointer       <= pointer + ADDR_W'(1);
              fill_rem      <= fill_rem - REM_W'(1);
              if (fill_rem == REM_W'(1)) state <= ST_IDLE;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    status                = '0;
    status[STAT_EMPTY]    = fifo_empty;
    status[STAT_FULL]     = fifo_full;
    status[STAT_BUSY]     = busy;
    status[STAT_OVERFLOW] = overflow;
  end

  always_comb begin
    io_rd_data = '0;
    case (io_sel)
      REG_ADDR:  io_rd_data = CPU_W'(pointer);
      REG_DATA:  io_rd_data = CPU_W'(fifo_count);
      REG_FILLV: io_rd_data = CPU_W'(fill_val);
      REG_FILLC: io_rd_data = CPU_W'(status);
      default:   io_rd_data = '0;
    endcase
  end

endmodule
